// File: rtl/car_update_sequencer_pkg.sv
// Shared definitions for the car update sequencer: state encoding, default
// car count, player index and an index-width helper.
package game_defs;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_DONE   = 2'd2
    } seq_state_t;

    localparam int CARS_DEFAULT = 6;
    localparam int PLAYER       = 0;

    // Width needed to index n items; never less than one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/car_update_sequencer_if.sv
// Request/index/acknowledge handshake between the sequencer (master) and the
// car movement units (slave).
interface car_update_sequencer_if #(
    parameter int IDXW = 3
);
    logic            upd_req;
    logic [IDXW-1:0] upd_idx;
    logic            upd_ack;

    modport master (output upd_req, output upd_idx, input upd_ack);
    modport slave  (input upd_req, input upd_idx, output upd_ack);
endinterface

// File: rtl/car_update_sequencer_collision_accumulator.sv
// Sticky per-car overlap set between the player car and every other car.
// hit_o already includes the current pixel so the frame summary taken on the
// last UPDATE cycle loses no sample. On clear_load_i the register restarts
// from the current pixel only, so nothing is dropped across the frame boundary.
module collision_accumulator
    import game_defs::*;
#(
    parameter int CARS = CARS_DEFAULT
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [CARS-1:0] on_cars_i,
    input  logic            clear_load_i,
    output logic [CARS-1:0] hit_o
);

    logic [CARS-1:0] hit_q;
    logic [CARS-1:0] term;

    // Overlap of the player car with each other car at this pixel.
    always_comb begin
        term = '0;
        for (int k = PLAYER + 1; k < CARS; k++) begin
            term[k] = on_cars_i[PLAYER] & on_cars_i[k];
        end
    end

    // Accumulate overlaps; restart from the current term on frame end.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hit_q <= '0;
        end else if (clear_load_i) begin
            hit_q <= term;
        end else begin
            hit_q <= hit_q | term;
        end
    end

    assign hit_o = hit_q | term;

endmodule

// File: rtl/car_update_sequencer.sv
// Frame-level car update scheduler. On each refresh tick it walks every car
// index over the request/ack handshake, then pulses frame_done.
// Optional collision reporting is built when COLLISION_DETECT_EN is defined;
// otherwise crash_o/crash_cars_o are tied low and on_cars_i is unused.
module car_update_sequencer
    import game_defs::*;
#(
    parameter int CARS    = CARS_DEFAULT,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   refr_tick_i,
    input  logic [CARS-1:0]        on_cars_i,
    input  logic                   clear_err_i,
    car_update_sequencer_if.master upd_if,
    output logic                   busy_o,
    output logic                   frame_done_o,
    output logic                   crash_o,
    output logic [CARS-1:0]        crash_cars_o,
    output logic                   timeout_err_o,
    output logic                   overrun_o
);

    localparam int              IDXW      = clog2(CARS);
    localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(CARS - 1);
    localparam logic [7:0]      TIMER_MAX = 8'(TIMEOUT - 1);

    seq_state_t      state_q;
    logic [IDXW-1:0] idx_q;
    logic [7:0]      timer_q;
    logic            upd_req_q;
    logic            busy_q;
    logic            frame_done_q;
    logic            timeout_err_q, timeout_err_d;
    logic            overrun_q, overrun_d;

    logic in_update, expired, advance, finish;

    assign in_update = (state_q == ST_UPDATE);
    assign expired   = in_update && (timer_q == TIMER_MAX);
    assign advance   = in_update && (upd_if.upd_ack || expired);
    assign finish    = advance && (idx_q == LAST_IDX);

    // Sticky error flags: clear first, so a same-cycle set wins.
    always_comb begin
        timeout_err_d = timeout_err_q;
        overrun_d     = overrun_q;
        if (clear_err_i) begin
            timeout_err_d = 1'b0;
            overrun_d     = 1'b0;
        end
        if (expired) timeout_err_d = 1'b1;
        if (refr_tick_i && (state_q != ST_IDLE)) overrun_d = 1'b1;
    end

    // Sequencing FSM with registered handshake and status outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            timer_q       <= '0;
            upd_req_q     <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            frame_done_q  <= 1'b0;
            timeout_err_q <= timeout_err_d;
            overrun_q     <= overrun_d;
            case (state_q)
                ST_IDLE: begin
                    if (refr_tick_i) begin
                        state_q   <= ST_UPDATE;
                        idx_q     <= '0;
                        timer_q   <= '0;
                        upd_req_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                ST_UPDATE: begin
                    if (finish) begin
                        state_q      <= ST_DONE;
                        upd_req_q    <= 1'b0;
                        frame_done_q <= 1'b1;
                    end else if (advance) begin
                        idx_q   <= idx_q + 1'b1;
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    upd_req_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign upd_if.upd_req = upd_req_q;
    assign upd_if.upd_idx = idx_q;
    assign busy_o         = busy_q;
    assign frame_done_o   = frame_done_q;
    assign timeout_err_o  = timeout_err_q;
    assign overrun_o      = overrun_q;

`ifdef COLLISION_DETECT_EN
    logic [CARS-1:0] hit;
    logic            crash_q;
    logic [CARS-1:0] crash_cars_q;

    collision_accumulator #(.CARS(CARS)) u_collision_accumulator (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .on_cars_i    (on_cars_i),
        .clear_load_i (state_q == ST_DONE),
        .hit_o        (hit)
    );

    // Capture the frame's collision set as the sequence enters DONE.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            crash_q      <= 1'b0;
            crash_cars_q <= '0;
        end else begin
            crash_q <= finish && (|hit);
            if (finish) crash_cars_q <= hit;
        end
    end

    assign crash_o      = crash_q;
    assign crash_cars_o = crash_cars_q;
`else
    logic unused_on_cars;
    assign unused_on_cars = ^on_cars_i;
    assign crash_o        = 1'b0;
    assign crash_cars_o   = '0;
`endif

endmodule

// File: tb/tb_car_update_sequencer.sv
// Directed bench for car_update_sequencer with CARS=6, TIMEOUT=4.
// Collision expectations follow COLLISION_DETECT_EN as compiled.
module tb_car_update_sequencer;

    logic       clk = 1'b0;
    logic       reset, refr_tick, clear_err, ack;
    logic [5:0] on_cars;
    logic       busy, frame_done, crash, timeout_err, overrun;
    logic [5:0] crash_cars;
    int         checks = 0;
    int         failures = 0;

`ifdef COLLISION_DETECT_EN
    localparam logic [5:0] EXP_CC_MID = 6'b000100;
    localparam logic [5:0] EXP_CC_ALL = 6'b111110;
    localparam logic       EXP_CRASH  = 1'b1;
`else
    localparam logic [5:0] EXP_CC_MID = 6'b000000;
    localparam logic [5:0] EXP_CC_ALL = 6'b000000;
    localparam logic       EXP_CRASH  = 1'b0;
`endif

    car_update_sequencer_if #(.IDXW(3)) upd_if ();
    assign upd_if.upd_ack = ack;

    car_update_sequencer #(.CARS(6), .TIMEOUT(4)) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .refr_tick_i   (refr_tick),
        .on_cars_i     (on_cars),
        .clear_err_i   (clear_err),
        .upd_if        (upd_if),
        .busy_o        (busy),
        .frame_done_o  (frame_done),
        .crash_o       (crash),
        .crash_cars_o  (crash_cars),
        .timeout_err_o (timeout_err),
        .overrun_o     (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"}, 32'(upd_if.upd_req), 0);
        chk({tag, "_idx"}, 32'(upd_if.upd_idx), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_fd"}, 32'(frame_done), 0);
        chk({tag, "_crash"}, 32'(crash), 0);
        chk({tag, "_cc"}, 32'(crash_cars), 0);
        chk({tag, "_terr"}, 32'(timeout_err), 0);
        chk({tag, "_ovr"}, 32'(overrun), 0);
    endtask

    // Immediate ack for every car; collision pattern applied while idx is 2..4.
    task automatic frame_acks(input string tag, input logic [5:0] pat_mid);
        for (int k = 0; k < 6; k++) begin
            chk({tag, "_idx"}, 32'(upd_if.upd_idx), 32'(k));
            chk({tag, "_req"}, 32'(upd_if.upd_req), 1);
            chk({tag, "_fd_early"}, 32'(frame_done), 0);
            on_cars = (k >= 2 && k <= 4) ? pat_mid : 6'b0;
            ack = 1'b1;
            tick();
            ack = 1'b0;
        end
        on_cars = 6'b0;
        chk({tag, "_fd"}, 32'(frame_done), 1);
        chk({tag, "_req_done"}, 32'(upd_if.upd_req), 0);
    endtask

    initial begin
        reset = 1'b1; refr_tick = 1'b0; clear_err = 1'b0; ack = 1'b0; on_cars = 6'b0;
        tick(); tick();
        chk_all_zero("reset");
        reset = 1'b0;
        tick();

        // Frame 1: ack one cycle after each request; frame_done 13 cycles after tick.
        refr_tick = 1'b1; tick(); refr_tick = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk("f1_idx", 32'(upd_if.upd_idx), 32'(k));
            chk("f1_busy", 32'(busy), 1);
            chk("f1_fd_early", 32'(frame_done), 0);
            tick();
            chk("f1_idx_hold", 32'(upd_if.upd_idx), 32'(k));
            ack = 1'b1; tick(); ack = 1'b0;
        end
        chk("f1_fd", 32'(frame_done), 1);
        chk("f1_busy_done", 32'(busy), 1);
        chk("f1_terr", 32'(timeout_err), 0);
        tick();
        chk("f1_fd_pulse", 32'(frame_done), 0);
        chk("f1_busy_idle", 32'(busy), 0);

        // Ack in IDLE is ignored.
        ack = 1'b1; tick(); ack = 1'b0;
        chk("idle_ack_req", 32'(upd_if.upd_req), 0);
        chk("idle_ack_busy", 32'(busy), 0);

        // Frame 2: car 3 never acks; held 4 cycles then times out.
        refr_tick = 1'b1; tick(); refr_tick = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk("f2_idx", 32'(upd_if.upd_idx), 32'(k));
            if (k != 3) begin
                ack = 1'b1; tick(); ack = 1'b0;
            end else begin
                for (int t = 0; t < 3; t++) begin
                    tick();
                    chk("f2_idx3_hold", 32'(upd_if.upd_idx), 3);
                    chk("f2_terr_pre", 32'(timeout_err), 0);
                end
                tick();
                chk("f2_terr_set", 32'(timeout_err), 1);
            end
        end
        chk("f2_fd", 32'(frame_done), 1);
        tick(); tick();
        chk("f2_terr_sticky", 32'(timeout_err), 1);
        clear_err = 1'b1; tick(); clear_err = 1'b0;
        chk("f2_terr_clear", 32'(timeout_err), 0);

        // Frame 3: overlap of player and car 2 for three cycles mid-frame.
        refr_tick = 1'b1; tick(); refr_tick = 1'b0;
        frame_acks("f3", 6'b000101);
        chk("f3_crash", 32'(crash), 32'(EXP_CRASH));
        chk("f3_cc", 32'(crash_cars), 32'(EXP_CC_MID));
        tick();
        chk("f3_crash_pulse", 32'(crash), 0);
        chk("f3_cc_hold", 32'(crash_cars), 32'(EXP_CC_MID));

        // Frame 4: no overlap.
        refr_tick = 1'b1; tick(); refr_tick = 1'b0;
        frame_acks("f4", 6'b000000);
        chk("f4_crash", 32'(crash), 0);
        chk("f4_cc", 32'(crash_cars), 0);
        tick();

        // Frame 5: second refr_tick two cycles after the first.
        refr_tick = 1'b1; tick(); refr_tick = 1'b0;
        tick();
        chk("f5_ovr_pre", 32'(overrun), 0);
        refr_tick = 1'b1; tick(); refr_tick = 1'b0;
        chk("f5_ovr", 32'(overrun), 1);
        frame_acks("f5", 6'b000000);
        tick();
        for (int t = 0; t < 3; t++) begin
            chk("f5_no_restart_busy", 32'(busy), 0);
            chk("f5_no_restart_fd", 32'(frame_done), 0);
            tick();
        end
        clear_err = 1'b1; tick(); clear_err = 1'b0;
        chk("ovr_clear", 32'(overrun), 0);

        // Frame 6: set beats clear; refr_tick in DONE counts as overrun.
        refr_tick = 1'b1; tick(); refr_tick = 1'b0;
        refr_tick = 1'b1; clear_err = 1'b1; tick(); refr_tick = 1'b0; clear_err = 1'b0;
        chk("f6_set_wins", 32'(overrun), 1);
        clear_err = 1'b1; tick(); clear_err = 1'b0;
        chk("f6_ovr_clear", 32'(overrun), 0);
        frame_acks("f6", 6'b000000);
        refr_tick = 1'b1; tick(); refr_tick = 1'b0;
        chk("f6_done_ovr", 32'(overrun), 1);
        chk("f6_done_busy", 32'(busy), 0);
        tick();
        chk("f6_no_start", 32'(upd_if.upd_req), 0);

        // Frame 7: reset while idx=2 aborts everything.
        refr_tick = 1'b1; tick(); refr_tick = 1'b0;
        for (int k = 0; k < 2; k++) begin
            ack = 1'b1; tick(); ack = 1'b0;
        end
        chk("f7_idx2", 32'(upd_if.upd_idx), 2);
        reset = 1'b1; tick(); reset = 1'b0;
        chk_all_zero("f7_rst");
        tick();
        chk("f7_no_fd", 32'(frame_done), 0);
        refr_tick = 1'b1; tick(); refr_tick = 1'b0;
        frame_acks("f7_restart", 6'b000000);
        tick();

        // Frame 8: all cars overlap for the whole frame; frame_done at n+7.
        on_cars = 6'b111111;
        refr_tick = 1'b1; tick(); refr_tick = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk("f8_idx", 32'(upd_if.upd_idx), 32'(k));
            ack = 1'b1; tick(); ack = 1'b0;
        end
        chk("f8_fd", 32'(frame_done), 1);
        chk("f8_crash", 32'(crash), 32'(EXP_CRASH));
        chk("f8_cc", 32'(crash_cars), 32'(EXP_CC_ALL));
        on_cars = 6'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
